frame_mem_responder: RTL and testbench

- Memory-side responder that executes the frame-buffer transactions granted by the memory I/O state machine.
- Write enable (MIMO_in_enable) lets drawing-engine writes through; read enable (MIMO_out_enable) lets VGA pixel fetches through.
- Drives the external 16-bit asynchronous SRAM through a strobe sequence with programmable access wait. The board top owns the SRAM_DQ tristate buffer.
- Short-circuits background-pixel reads to a constant colour without touching SRAM.

---
 rtl/frame_mem_pkg.sv | 22 ++
 rtl/access_wait_counter.sv | 39 +++
 rtl/frame_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_frame_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_mem_pkg.sv
// Shared types and constants for the frame-buffer SRAM responder.
package frame_mem_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;

    // Width of the access-wait counter; covers WAIT_CYCLES 0..7.
    localparam int CNT_W = 3;

    // Colour returned for background-pixel reads without an SRAM access.
    localparam logic [15:0] BG_COLOR = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

endpackage

// File: rtl/access_wait_counter.sv
// Down-counter that times the SRAM strobe width for both read and write paths.
module access_wait_counter
    import frame_mem_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; saturates at zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/frame_mem_responder.sv
// Executes granted frame-buffer reads/writes against an async 16-bit SRAM.
module frame_mem_responder
    import frame_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MIMO_in_enable,
    input  logic              MIMO_out_enable,
    input  logic              Is_background,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              Drive_en,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam logic [CNT_W-1:0] WAIT_VAL = CNT_W'(WAIT_CYCLES);

    state_t            state_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] data_to_sram_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              drive_en_q;
    logic              ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;

    logic rd_accept, wr_accept;
    logic cnt_load, cnt_dec, cnt_zero;

    // Handshakes: reads win over writes so pixel fetches are never starved.
    always_comb begin
        rd_ready  = (state_q == IDLE) && MIMO_out_enable && !Reset;
        wr_ready  = (state_q == IDLE) && MIMO_in_enable && !Reset
                    && !(rd_req && MIMO_out_enable);
        rd_accept = rd_ready && rd_req;
        wr_accept = wr_ready && wr_valid;
        cnt_load  = ((state_q == IDLE) && rd_accept && !Is_background)
                    || (state_q == WR_SETUP);
        cnt_dec   = (state_q == RD_ACCESS) || (state_q == WR_PULSE);
    end

    access_wait_counter u_wait (
        .clk_i      (Clk),
        .reset_i    (Reset),
        .load_i     (cnt_load),
        .load_val_i (WAIT_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Transaction FSM; every SRAM-facing output is a register set on the transition.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            sram_addr_q    <= '0;
            data_to_sram_q <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            drive_en_q     <= 1'b0;
            ce_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            ub_n_q         <= 1'b1;
            lb_n_q         <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_accept) begin
                        sram_addr_q <= rd_addr;
                        if (Is_background) begin
                            rd_data_q  <= DATA_W'(BG_COLOR);
                            rd_valid_q <= 1'b1;
                            state_q    <= RD_DONE;
                        end else begin
                            ce_n_q     <= 1'b0;
                            oe_n_q     <= 1'b0;
                            ub_n_q     <= 1'b0;
                            lb_n_q     <= 1'b0;
                            drive_en_q <= 1'b0;
                            state_q    <= RD_ACCESS;
                        end
                    end else if (wr_accept) begin
                        sram_addr_q    <= wr_addr;
                        data_to_sram_q <= wr_data;
                        ce_n_q         <= 1'b0;
                        ub_n_q         <= 1'b0;
                        lb_n_q         <= 1'b0;
                        we_n_q         <= 1'b1;
                        drive_en_q     <= 1'b1;
                        state_q        <= WR_SETUP;
                    end
                end
                RD_ACCESS: begin
                    if (cnt_zero) begin
                        rd_data_q  <= Data_from_SRAM;
                        rd_valid_q <= 1'b1;
                        ce_n_q     <= 1'b1;
                        oe_n_q     <= 1'b1;
                        ub_n_q     <= 1'b1;
                        lb_n_q     <= 1'b1;
                        state_q    <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    state_q <= IDLE;
                end
                WR_SETUP: begin
                    we_n_q  <= 1'b0;
                    state_q <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt_zero) begin
                        we_n_q  <= 1'b1;
                        state_q <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    drive_en_q <= 1'b0;
                    ce_n_q     <= 1'b1;
                    ub_n_q     <= 1'b1;
                    lb_n_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SRAM_ADDR    = sram_addr_q;
    assign Data_to_SRAM = data_to_sram_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign Drive_en     = drive_en_q;
    assign SRAM_CE_N    = ce_n_q;
    assign SRAM_OE_N    = oe_n_q;
    assign SRAM_WE_N    = we_n_q;
    assign SRAM_UB_N    = ub_n_q;
    assign SRAM_LB_N    = lb_n_q;

endmodule

// File: tb/tb_frame_mem_responder.sv
// Directed bench for frame_mem_responder with WAIT_CYCLES=1.
module tb_frame_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MIMO_in_enable, MIMO_out_enable, Is_background;
    logic        wr_valid, wr_ready, rd_req, rd_ready, rd_valid;
    logic [19:0] wr_addr, rd_addr, SRAM_ADDR;
    logic [15:0] wr_data, rd_data, Data_to_SRAM, Data_from_SRAM;
    logic        Drive_en, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    int tests = 0;
    int fails = 0;
    int rv_count = 0;
    int rv_snap;

    frame_mem_responder #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .MIMO_in_enable  (MIMO_in_enable),
        .MIMO_out_enable (MIMO_out_enable),
        .Is_background   (Is_background),
        .wr_valid        (wr_valid),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .SRAM_ADDR       (SRAM_ADDR),
        .Data_to_SRAM    (Data_to_SRAM),
        .Data_from_SRAM  (Data_from_SRAM),
        .Drive_en        (Drive_en),
        .SRAM_CE_N       (SRAM_CE_N),
        .SRAM_OE_N       (SRAM_OE_N),
        .SRAM_WE_N       (SRAM_WE_N),
        .SRAM_UB_N       (SRAM_UB_N),
        .SRAM_LB_N       (SRAM_LB_N)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Counts rd_valid pulses and guards against bus contention.
    always @(negedge Clk) begin
        if (rd_valid === 1'b1) rv_count++;
        tests++;
        assert (!(Drive_en === 1'b1 && SRAM_OE_N === 1'b0)) else begin
            fails++;
            $error("FAIL contention observed Drive_en=%b OE_N=%b expected not both active",
                   Drive_en, SRAM_OE_N);
        end
    end

    initial begin
        Reset = 1'b1;
        MIMO_in_enable = 1'b0; MIMO_out_enable = 1'b0; Is_background = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0; Data_from_SRAM = '0;

        // Reset held two cycles, then idle.
        tick(); tick();
        check("rst_ce", 32'(SRAM_CE_N), 32'd1);
        check("rst_oe", 32'(SRAM_OE_N), 32'd1);
        check("rst_we", 32'(SRAM_WE_N), 32'd1);
        check("rst_ublb", 32'({SRAM_UB_N, SRAM_LB_N}), 32'd3);
        check("rst_drive", 32'(Drive_en), 32'd0);
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_dout", 32'(Data_to_SRAM), 32'd0);
        check("rst_rdata", 32'(rd_data), 32'd0);
        check("rst_ready", 32'({rd_ready, wr_ready}), 32'd0);
        Reset = 1'b0;
        tick(); tick(); tick();
        check("idle_ce", 32'(SRAM_CE_N), 32'd1);
        check("idle_drive", 32'(Drive_en), 32'd0);
        check("idle_no_rvalid", 32'(rv_count), 32'd0);

        // SRAM read: data only presented in the capture cycle.
        MIMO_out_enable = 1'b1; rd_req = 1'b1; rd_addr = 20'h000A5;
        #1;
        check("rd_ready", 32'(rd_ready), 32'd1);
        check("rd_wr_ready", 32'(wr_ready), 32'd0);
        tick();                                   // accept edge
        rd_req = 1'b0;
        check("rd_c1_addr", 32'(SRAM_ADDR), 32'h000A5);
        check("rd_c1_oe", 32'(SRAM_OE_N), 32'd0);
        check("rd_c1_ce", 32'(SRAM_CE_N), 32'd0);
        check("rd_c1_valid", 32'(rd_valid), 32'd0);
        check("rd_c1_ready", 32'(rd_ready), 32'd0);
        tick();
        Data_from_SRAM = 16'hBEEF;
        check("rd_c2_oe", 32'(SRAM_OE_N), 32'd0);
        check("rd_c2_valid", 32'(rd_valid), 32'd0);
        tick();
        Data_from_SRAM = 16'h0000;
        check("rd_c3_valid", 32'(rd_valid), 32'd1);
        check("rd_c3_data", 32'(rd_data), 32'h0000BEEF);
        check("rd_c3_oe", 32'(SRAM_OE_N), 32'd1);
        tick();
        check("rd_c4_valid", 32'(rd_valid), 32'd0);
        check("rd_c4_hold", 32'(rd_data), 32'h0000BEEF);
        check("rd_c4_ready", 32'(rd_ready), 32'd1);

        // Background read: constant colour, no strobe.
        rd_req = 1'b1; Is_background = 1'b1; rd_addr = 20'h00003;
        tick();
        rd_req = 1'b0; Is_background = 1'b0;
        check("bg_valid", 32'(rd_valid), 32'd1);
        check("bg_data", 32'(rd_data), 32'h0);
        check("bg_oe", 32'(SRAM_OE_N), 32'd1);
        check("bg_ce", 32'(SRAM_CE_N), 32'd1);
        tick();
        check("bg_valid_end", 32'(rd_valid), 32'd0);

        // Write; enable dropped mid-transaction must not abort it.
        MIMO_out_enable = 1'b0; MIMO_in_enable = 1'b1;
        wr_valid = 1'b1; wr_addr = 20'h00100; wr_data = 16'h1234;
        #1;
        check("wr_ready", 32'(wr_ready), 32'd1);
        tick();                                   // accept edge
        wr_valid = 1'b0; wr_data = 16'h0000; MIMO_in_enable = 1'b0;
        check("wr_setup_drive", 32'(Drive_en), 32'd1);
        check("wr_setup_we", 32'(SRAM_WE_N), 32'd1);
        check("wr_setup_ce", 32'(SRAM_CE_N), 32'd0);
        check("wr_addr", 32'(SRAM_ADDR), 32'h00100);
        check("wr_data", 32'(Data_to_SRAM), 32'h1234);
        tick();
        check("wr_pulse1_we", 32'(SRAM_WE_N), 32'd0);
        check("wr_pulse1_drive", 32'(Drive_en), 32'd1);
        tick();
        check("wr_pulse2_we", 32'(SRAM_WE_N), 32'd0);
        tick();
        MIMO_in_enable = 1'b1;
        #1;
        check("wr_hold_we", 32'(SRAM_WE_N), 32'd1);
        check("wr_hold_drive", 32'(Drive_en), 32'd1);
        check("wr_hold_ready", 32'(wr_ready), 32'd0);
        tick();
        check("wr_done_drive", 32'(Drive_en), 32'd0);
        check("wr_done_ce", 32'(SRAM_CE_N), 32'd1);
        check("wr_done_ready", 32'(wr_ready), 32'd1);

        // Read and write together: read first, write at next IDLE.
        MIMO_out_enable = 1'b1; rd_req = 1'b1; Is_background = 1'b1;
        wr_valid = 1'b1; wr_addr = 20'h00200; wr_data = 16'h5678;
        #1;
        check("both_rd_ready", 32'(rd_ready), 32'd1);
        check("both_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        rd_req = 1'b0; Is_background = 1'b0;
        check("both_rvalid", 32'(rd_valid), 32'd1);
        check("both_busy_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        check("both_wr_ready_idle", 32'(wr_ready), 32'd1);
        tick();                                   // write accepted
        wr_valid = 1'b0;
        check("both_wr_drive", 32'(Drive_en), 32'd1);
        check("both_wr_addr", 32'(SRAM_ADDR), 32'h00200);
        check("both_wr_data", 32'(Data_to_SRAM), 32'h5678);
        tick();
        check("both_wr_pulse", 32'(SRAM_WE_N), 32'd0);

        // Reset during WR_PULSE abandons the write.
        Reset = 1'b1;
        tick();
        check("rstw_we", 32'(SRAM_WE_N), 32'd1);
        check("rstw_drive", 32'(Drive_en), 32'd0);
        check("rstw_ce", 32'(SRAM_CE_N), 32'd1);
        Reset = 1'b0;
        #1;
        check("rstw_idle", 32'(rd_ready), 32'd1);

        // Reset during RD_ACCESS suppresses rd_valid.
        rd_req = 1'b1; rd_addr = 20'h00777;
        tick();
        rd_req = 1'b0;
        check("rstr_oe", 32'(SRAM_OE_N), 32'd0);
        rv_snap = rv_count;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rstr_oe_off", 32'(SRAM_OE_N), 32'd1);
        tick(); tick(); tick(); tick();
        check("rstr_no_rvalid", 32'(rv_count - rv_snap), 32'd0);
        check("rstr_rdata", 32'(rd_data), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
